// File: rtl/dram_rd_pkg.sv
// Shared types and helpers for the DRAM readback controller.
package dram_rd_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLatch,
      StIssue,
      StWaitCredit,
      StDrain
   } rd_state_e;

   localparam logic [15:0] HdrMagic = 16'hD4A7;
   localparam int unsigned BURST_CNT_W = 5;

   // Caller truncates to its address width, which gives the modulo wrap.
   function automatic logic [31:0] wrap_start(input logic [15:0] ts,
                                              input int unsigned beats_per_ts,
                                              input int unsigned pre_beats);
      return (32'(ts) * beats_per_ts) - pre_beats;
   endfunction

endpackage

// File: rtl/dram_rd_fifo.sv
// Show-ahead FIFO with registered write; caller never pushes when full or pops when empty.
module dram_rd_fifo #(
   parameter int unsigned DATA_W     = 256,
   parameter int unsigned FIFO_DEPTH = 32,
   localparam int unsigned PtrW      = $clog2(FIFO_DEPTH),
   localparam int unsigned LvlW      = PtrW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic [LvlW-1:0]   level
);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LvlW-1:0]   level_q;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_q + LvlW'(push) - LvlW'(pop);
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign level = level_q;

endmodule

// File: rtl/dram_readback_ctrl.sv
// Reads a trigger-centred window back from DRAM in credit-guarded bursts and streams it out.
// Define DRAM_RD_HEADER_EN to prepend a descriptor beat to every window.
module dram_readback_ctrl
   import dram_rd_pkg::*;
#(
   parameter int unsigned ADDR_W       = 25,
   parameter int unsigned DATA_W       = 256,
   parameter int unsigned BURST_LEN    = 16,
   parameter int unsigned BEATS_PER_TS = 1,
   parameter int unsigned PRE_BEATS    = 256,
   parameter int unsigned TOTAL_BEATS  = 1024,
   parameter int unsigned FIFO_DEPTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   triggering_status,
   input  logic [15:0]            triggering_time_stamp,
   input  logic                   DRAM_Wait_Request,
   output logic                   DRAM_Read_Enable,
   output logic                   DRAM_Read_Burst_Begin,
   output logic [BURST_CNT_W-1:0] DRAM_Read_Burst_Count,
   output logic [ADDR_W-1:0]      DRAM_Read_Addr,
   input  logic [DATA_W-1:0]      DRAM_Read_Data,
   input  logic                   DRAM_Read_Valid,
   output logic [DATA_W-1:0]      PC_data,
   output logic                   PC_valid,
   input  logic                   PC_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow_err
);

   localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
`ifdef DRAM_RD_HEADER_EN
   localparam int unsigned TotalPops = TOTAL_BEATS + 1;
`else
   localparam int unsigned TotalPops = TOTAL_BEATS;
`endif

   rd_state_e              state_q, state_d;
   logic                   trig_q, pending_q, pending_d, done_q, done_d, ovf_q, ovf_d;
   logic [15:0]            ts_q, ts_d;
   logic [ADDR_W-1:0]      addr_q, addr_d, start_addr;
   logic [31:0]            remaining_q, remaining_d, outstanding_q, outstanding_d;
   logic [31:0]            popped_q, popped_d;
   logic [BURST_CNT_W-1:0] count;
   logic                   credit_ok, accept, beat_in, fifo_full, hdr_push, push, pop;
   logic [DATA_W-1:0]      push_data, fifo_dout;
   logic [LvlW-1:0]        level;

   assign start_addr = ADDR_W'(wrap_start(ts_q, BEATS_PER_TS, PRE_BEATS));

   always_comb begin
      count = BURST_CNT_W'(BURST_LEN);
      if (remaining_q < 32'(BURST_LEN)) count = remaining_q[BURST_CNT_W-1:0];
   end

   // level + outstanding never exceeds FIFO_DEPTH, so this cannot underflow.
   assign credit_ok = (32'(FIFO_DEPTH) - 32'(level) - outstanding_q) >= 32'(count);

   assign DRAM_Read_Enable      = (state_q == StIssue) && credit_ok;
   assign DRAM_Read_Burst_Begin = DRAM_Read_Enable && !pending_q;
   assign DRAM_Read_Burst_Count = DRAM_Read_Enable ? count : '0;
   assign DRAM_Read_Addr        = DRAM_Read_Enable ? addr_q : '0;
   assign accept                = DRAM_Read_Enable && !DRAM_Wait_Request;

   assign beat_in   = DRAM_Read_Valid && (state_q != StIdle);
   assign fifo_full = (level == LvlW'(FIFO_DEPTH));

`ifdef DRAM_RD_HEADER_EN
   assign hdr_push  = (state_q == StLatch);
   assign push_data = hdr_push ? DATA_W'({HdrMagic, ts_q, 7'b0, 25'(start_addr),
                                          32'(TOTAL_BEATS)}) : DRAM_Read_Data;
`else
   assign hdr_push  = 1'b0;
   assign push_data = DRAM_Read_Data;
`endif
   assign push = hdr_push || (beat_in && !fifo_full);

   assign PC_valid     = (level != '0);
   assign pop          = PC_valid && PC_ready;
   assign PC_data      = PC_valid ? fifo_dout : '0;
   assign busy         = (state_q != StIdle);
   assign done         = done_q;
   assign overflow_err = ovf_q;

   always_comb begin
      state_d       = state_q;
      ts_d          = ts_q;
      addr_d        = addr_q;
      remaining_d   = remaining_q;
      pending_d     = pending_q;
      popped_d      = popped_q + 32'(pop);
      done_d        = 1'b0;
      ovf_d         = ovf_q || (beat_in && fifo_full);
      outstanding_d = outstanding_q + (accept ? 32'(count) : 32'd0) - 32'(beat_in);
      unique case (state_q)
         StIdle: begin
            if (triggering_status && !trig_q) begin
               ts_d    = triggering_time_stamp;
               state_d = StLatch;
            end
         end
         StLatch: begin
            addr_d      = start_addr;
            remaining_d = 32'(TOTAL_BEATS);
            popped_d    = '0;
            pending_d   = 1'b0;
            state_d     = StIssue;
         end
         StIssue: begin
            if (accept) begin
               addr_d      = addr_q + ADDR_W'(count);
               remaining_d = remaining_q - 32'(count);
               pending_d   = 1'b0;
               if (remaining_q == 32'(count)) state_d = StDrain;
            end else if (DRAM_Read_Enable) begin
               pending_d = 1'b1;
            end else begin
               state_d = StWaitCredit;
            end
         end
         StWaitCredit: begin
            if (credit_ok) state_d = StIssue;
         end
         StDrain: begin
            if (pop && (popped_q == 32'(TotalPops - 1))) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         trig_q        <= 1'b0;
         ts_q          <= '0;
         addr_q        <= '0;
         remaining_q   <= '0;
         outstanding_q <= '0;
         popped_q      <= '0;
         pending_q     <= 1'b0;
         done_q        <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         trig_q        <= triggering_status;
         ts_q          <= ts_d;
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         outstanding_q <= outstanding_d;
         popped_q      <= popped_d;
         pending_q     <= pending_d;
         done_q        <= done_d;
         ovf_q         <= ovf_d;
      end
   end

   dram_rd_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (push_data),
      .pop   (pop),
      .rdata (fifo_dout),
      .level (level)
   );

endmodule

// File: tb/tb_dram_readback_ctrl.sv
// Scoreboard bench for dram_readback_ctrl with a 40-beat window (bursts of 16, 16, 8).
module tb_dram_readback_ctrl;

   localparam int unsigned AW  = 25;
   localparam int unsigned DW  = 256;
   localparam int unsigned TOT = 40;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          trig = 1'b0;
   logic [15:0]   ts = '0;
   logic          wait_req = 1'b0;
   logic          rd_en, bb;
   logic [4:0]    bc;
   logic [AW-1:0] ra;
   logic [DW-1:0] rdata = '0;
   logic          rvalid = 1'b0;
   logic [DW-1:0] pc_data;
   logic          pc_valid, busy, done, ovf;
   logic          pc_ready = 1'b1;

   dram_readback_ctrl #(
      .TOTAL_BEATS (TOT)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .triggering_status     (trig),
      .triggering_time_stamp (ts),
      .DRAM_Wait_Request     (wait_req),
      .DRAM_Read_Enable      (rd_en),
      .DRAM_Read_Burst_Begin (bb),
      .DRAM_Read_Burst_Count (bc),
      .DRAM_Read_Addr        (ra),
      .DRAM_Read_Data        (rdata),
      .DRAM_Read_Valid       (rvalid),
      .PC_data               (pc_data),
      .PC_valid              (pc_valid),
      .PC_ready              (pc_ready),
      .busy                  (busy),
      .done                  (done),
      .overflow_err          (ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] exp_data[$];
   logic [AW-1:0] exp_addr[$];
   logic [4:0]    exp_cnt[$];
   logic [AW-1:0] resp_addr[$];
   logic [4:0]    resp_cnt[$];

   int done_cnt = 0, acc_bursts = 0, beats_req = 0, beats_pop = 0, max_inflight = 0;
   int bb_cnt = 0, stall_seen = 0;
   int stall_at = -1, stall_req = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] beat_of(input logic [AW-1:0] a);
      logic [31:0] w;
      w = 32'(a) ^ 32'hC0DE0000;
      return {8{w}};
   endfunction

   // Monitor: request channel, output stream, done pulses, in-flight bound.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            beats_req = 0;
            beats_pop = 0;
            bb_cnt    = 0;
         end else begin
            if (rd_en) begin
               if (bb) bb_cnt++;
               if (wait_req) stall_seen++;
               if (exp_addr.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_req: got addr %0h cnt %0d required none", ra, bc);
               end else begin
                  check("req_addr", DW'(ra), DW'(exp_addr[0]));
                  check("req_cnt", DW'(bc), DW'(exp_cnt[0]));
               end
               if (!wait_req) begin
                  check("burst_begin_once", DW'(bb_cnt), DW'(1));
                  bb_cnt = 0;
                  if (exp_addr.size() != 0) begin
                     void'(exp_addr.pop_front());
                     void'(exp_cnt.pop_front());
                  end
                  resp_addr.push_back(ra);
                  resp_cnt.push_back(bc);
                  beats_req += int'(bc);
                  acc_bursts++;
               end
            end
            if (pc_valid && pc_ready) begin
               beats_pop++;
               if (exp_data.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat: got %0h required none", pc_data);
               end else begin
                  check("pc_data", pc_data, exp_data.pop_front());
               end
            end
            if (done) done_cnt++;
            if (beats_req - beats_pop > max_inflight) max_inflight = beats_req - beats_pop;
         end
      end
   end

   // DRAM read responder: returns accepted bursts one beat per cycle, optional stall.
   initial begin
      logic [AW-1:0] cur_addr;
      int            cur_left;
      cur_addr = '0;
      cur_left = 0;
      forever begin
         @(posedge clk);
         #1;
         if (cur_left == 0 && resp_addr.size() != 0) begin
            cur_addr = resp_addr.pop_front();
            cur_left = int'(resp_cnt.pop_front());
         end
         if (cur_left > 0) begin
            rvalid   = 1'b1;
            rdata    = beat_of(cur_addr);
            cur_addr = cur_addr + 1'b1;
            cur_left--;
         end else begin
            rvalid = 1'b0;
            rdata  = '0;
         end
         wait_req = (acc_bursts == stall_at) && (stall_seen < stall_req);
      end
   end

   task automatic arm(input logic [15:0] t, input logic [AW-1:0] start);
      for (int i = 0; i < 3; i++) begin
         exp_addr.push_back(start + AW'(16 * i));
         exp_cnt.push_back((i == 2) ? 5'd8 : 5'd16);
      end
`ifdef DRAM_RD_HEADER_EN
      exp_data.push_back(DW'({16'hD4A7, t, 7'b0, 25'(start), 32'(TOT)}));
`endif
      for (int i = 0; i < int'(TOT); i++) exp_data.push_back(beat_of(start + AW'(i)));
      @(posedge clk);
      #1;
      trig = 1'b1;
      ts   = t;
   endtask

   task automatic wait_done(input string name, input int d0);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == d0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got no done required done within 3000 cycles", name);
      end
      repeat (3) @(negedge clk);
      check({name, "_done_once"}, DW'(done_cnt - d0), DW'(1));
      check({name, "_beats_left"}, DW'(exp_data.size()), DW'(0));
      check({name, "_bursts_left"}, DW'(exp_addr.size()), DW'(0));
      check({name, "_idle"}, DW'({busy, pc_valid}), DW'(0));
   endtask

   initial begin
      int d0, s0, n;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_outs", DW'({rd_en, bb, bc, ra, pc_valid, busy, done, ovf}), DW'(0));
      check("reset_pc_data", pc_data, DW'(0));

      // Plain window, start 0x0400 - 0x100 = 0x0300; first request two cycles after edge.
      d0 = done_cnt;
      arm(16'h0400, 25'h0000300);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("first_req_latency", DW'({rd_en, bb, busy}), DW'(3'b111));
      check("first_req_addr", DW'(ra), DW'(25'h0000300));
      wait_done("plain", d0);
      @(posedge clk);
      #1 trig = 1'b0;

      // Start 0x00FF - 0x100 wraps to 0x1FFFFFF; second burst at 0x000000F stalled 3 cycles.
      d0 = done_cnt;
      s0 = stall_seen;
      stall_at  = acc_bursts + 1;
      stall_req = stall_seen + 3;
      arm(16'h00FF, 25'h1FFFFFF);
      wait_done("wrap_stall", d0);
      check("stall_cycles", DW'(stall_seen - s0), DW'(3));
      @(posedge clk);
      #1 trig = 1'b0;

      // Backpressure, ignored re-trigger while busy, held level after done.
      d0 = done_cnt;
      arm(16'h0123, 25'h0000023);
      repeat (10) @(posedge clk);
      #1 pc_ready = 1'b0;
      trig = 1'b0;
      @(posedge clk);
      #1 trig = 1'b1;
      ts = 16'h0777;
      repeat (200) @(posedge clk);
      #1 pc_ready = 1'b1;
      wait_done("backpressure", d0);
      check("inflight_le_depth", DW'(max_inflight <= 32), DW'(1));
      check("no_overflow", DW'(ovf), DW'(0));
      repeat (50) @(negedge clk);
      check("no_retrigger", DW'({done_cnt - d0, busy}), DW'({32'd1, 1'b0}));
      @(posedge clk);
      #1 trig = 1'b0;

      // Reset mid-burst, stale beats arrive, then a clean window.
      s0 = acc_bursts;
      arm(16'h0500, 25'h0000400);
      n = 0;
      while (acc_bursts == s0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      trig = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_data.delete();
      exp_addr.delete();
      exp_cnt.delete();
      @(negedge clk);
      check("midrst_outs", DW'({rd_en, bb, bc, ra, pc_valid, busy, done, ovf}), DW'(0));
      check("midrst_pc_data", pc_data, DW'(0));
      n = 0;
      while ((resp_addr.size() != 0 || rvalid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("stale_discarded", DW'({pc_valid, busy, ovf}), DW'(0));
      d0 = done_cnt;
      arm(16'h0200, 25'h0000100);
      wait_done("after_reset", d0);
      check("final_no_overflow", DW'(ovf), DW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dram_readback_ctrl.md
# dram_readback_ctrl

Read-side counterpart of `DRAM_Addr_Gen`. After the thresholder raises `triggering_status`, this block computes a capture window around `triggering_time_stamp` and reads that window back from DRAM as Avalon-MM read bursts. Returned beats are buffered in a credit-guarded FIFO and streamed to the UDP/PC path over a valid/ready interface. It sits between the DRAM controller read port and `UDP_Control`.

## Interface
- `ADDR_W`, 25, DRAM word-address width
- `DATA_W`, 256, DRAM beat width
- `BURST_LEN`, 16, maximum beats per read burst (1..16)
- `BEATS_PER_TS`, 1, DRAM beats per timestamp tick (power of two)
- `PRE_BEATS`, 256, beats read before the trigger address
- `TOTAL_BEATS`, 1024, window length in beats
- `FIFO_DEPTH`, 32, readback FIFO depth (power of two, ≥ BURST_LEN)
- `clk`  in  1  single clock
- `rst_n`  in  1  synchronous, active-low reset
- `triggering_status`  in  1  thresholder decision (level)
- `triggering_time_stamp`  in  16  trigger timestamp; valid while `triggering_status`=1
- `DRAM_Wait_Request`  in  1  controller stall
- `DRAM_Read_Enable`  out  1  read request
- `DRAM_Read_Burst_Begin`  out  1  first cycle of each request
- `DRAM_Read_Burst_Count`  out  5  beats in this burst
- `DRAM_Read_Addr`  out  ADDR_W  burst start address
- `DRAM_Read_Data`  in  DATA_W  returned beat
- `DRAM_Read_Valid`  in  1  returned beat valid
- `PC_data`  out  DATA_W  stream data
- `PC_valid`  out  1  stream valid
- `PC_ready`  in  1  stream ready
- `busy`  out  1  readback in progress
- `done`  out  1  one-cycle pulse when the last beat is popped
- `overflow_err`  out  1  sticky: Read_Valid arrived with FIFO full

## Operation
- Trigger is the rising edge of `triggering_status`, using a registered previous value. An edge seen while not IDLE is ignored. A held-high level never retriggers.
- Start address is `start = (ts * BEATS_PER_TS − PRE_BEATS) mod 2^ADDR_W`. Compute it in ADDR_W bits, zero-extending ts. Every subsequent address also wraps mod 2^ADDR_W.
- State machine: IDLE → LATCH (capture start, set remaining=TOTAL_BEATS) → ISSUE ⇄ WAIT_CREDIT → DRAIN → IDLE.
- ISSUE:
  - `count = min(BURST_LEN, remaining)`.
  - A request is issued only if `FIFO_DEPTH − fifo_level − outstanding ≥ count`. Otherwise go to WAIT_CREDIT.
  - A request is accepted on a cycle with `Read_Enable & !Wait_Request`. On acceptance: addr += count, remaining −= count, outstanding += count.
  - When remaining reaches 0, go to DRAIN.
- Handshake while `Wait_Request`=1: hold `Read_Enable`, `Read_Addr` and `Burst_Count` stable. `Burst_Begin` is high only on the first cycle of each request, never while stalled.
- Each `Read_Valid` beat is written to the FIFO and decrements `outstanding`. If outstanding is incremented and decremented in the same cycle, apply both.
- `PC_valid` = FIFO non-empty. The FIFO pops on `PC_valid & PC_ready`. `PC_data` holds stable while `PC_valid & !PC_ready`.
- DRAIN ends when the popped count reaches TOTAL_BEATS (plus header beat if configured). At that point `done` pulses for 1 cycle and the state returns to IDLE.
- `Read_Valid` in IDLE (stale beats after a reset) is discarded and not counted.
- `Read_Valid` with the FIFO full sets `overflow_err` and the beat is dropped. Credit accounting makes this unreachable under a compliant controller.

## Timing
- Reset values: all outputs 0. The FIFO, `outstanding`, `remaining` and the edge register are cleared. `overflow_err` clears only on reset.
- Trigger edge sampled at cycle t. LATCH is at t+1. The first `Read_Enable`/`Burst_Begin` is at t+2.
- Back-to-back bursts: the next request asserts the cycle after acceptance, if credit allows.
- `Read_Valid` at cycle c into an empty FIFO → `PC_valid`=1 at c+1 (registered write, show-ahead read).
- Sustained throughput is 1 beat/cycle when `PC_ready`=1 and credit is available.
- Reset mid-operation takes effect the next edge. In-flight bursts are abandoned.
- `busy` = state ≠ IDLE.

## Configuration
- `DRAM_RD_HEADER_EN` defined:
  - The first PC beat is a header, zero-padded to DATA_W: `{16'hD4A7, ts[15:0], 7'b0, start[24:0], TOTAL_BEATS[31:0]}` in the LSBs.
  - The header is injected ahead of FIFO data and reserves one FIFO credit.
  - `done` follows TOTAL_BEATS+1 pops.
- Undefined: data beats only; `done` follows TOTAL_BEATS pops.

## Structure
- Package `dram_rd_pkg`:
  - state enum
  - header magic `16'hD4A7`
  - `BURST_CNT_W=5`
  - function for wrapped start-address computation
- Sub-module `dram_rd_fifo`: synchronous show-ahead FIFO with `level` output, parameterized by DATA_W/FIFO_DEPTH.

## Test plan
- ts=16'h0400, defaults, controller never stalls, `PC_ready`=1:
  - Request sequence is 64 bursts of count 16.
  - First address 0x0300, last 0x06F0.
  - 1024 beats delivered in order, `done` pulses once.
- ts=16'h0010: start = 0x1FFFF10. The 16th burst address is 0x0000000 (wrap), and data order is preserved.
- `Wait_Request` held high for 3 cycles on burst 2:
  - `Read_Addr`/`Burst_Count` stable across the stall.
  - `Burst_Begin` high for exactly 1 cycle.
- `PC_ready`=0 for 200 cycles mid-window: `outstanding + level ≤ 32` at all times, `overflow_err` stays 0, and no beat is lost or duplicated.
- TOTAL_BEATS=40, BURST_LEN=16: counts are 16, 16, 8. A second trigger edge while busy is ignored. Holding the trigger high after `done` does not restart.
- Reset asserted mid-burst, then stale `Read_Valid` beats arrive: all outputs are 0, stale beats are discarded, and a new trigger starts a clean window.
